// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronizes ps2_clk/ps2_data, deserializes 11-bit frames and
// holds the scan code behind a ready/read handshake. Define PS2_PARITY_CHECK_EN to reject bad parity.
module ps2_kbd_rx #(
   parameter int TIMEOUT_CYCLES = 2000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       rd,
   output logic [7:0] kbd_data,
   output logic       kbd_ready,
   output logic       overrun,
   output logic       frame_err
);

   localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

`ifdef PS2_PARITY_CHECK_EN
   localparam logic PARITY_EN = 1'b1;
`else
   localparam logic PARITY_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_CHECK = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [1:0]        r_clk_sync;
   logic [1:0]        r_data_sync;
   logic              r_clk_prev;
   logic [9:0]        r_sreg;
   logic [3:0]        r_bitcnt;
   logic [TO_W-1:0]   r_to_cnt;
   logic [7:0]        r_kbd_data;
   logic              r_kbd_ready;
   logic              r_overrun;
   logic              r_frame_err;

   logic              w_fall;
   logic              w_sample;
   logic              w_timeout;
   logic              w_err_next;
   logic              w_frame_ok;
   logic              w_accept;
   logic              w_load;

   assign w_fall     = r_clk_prev & ~r_clk_sync[1];
   assign w_sample   = r_data_sync[1];
   // After 10 shifts: sreg[9]=stop, sreg[8]=parity, sreg[7:0]=data; odd parity over data+parity.
   assign w_frame_ok = r_sreg[9] & (~PARITY_EN | (^r_sreg[8:0]));
   assign w_accept   = (r_state == S_CHECK) & w_frame_ok;
   assign w_load     = w_accept & (~r_kbd_ready | rd);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_err_next   = 1'b0;
      w_timeout    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_fall) begin
               if (!w_sample) begin
                  w_state_next = S_SHIFT;
               end else begin
                  w_err_next = 1'b1;
               end
            end
         end
         S_SHIFT: begin
            if (w_fall) begin
               if (r_bitcnt == 4'd9) begin
                  w_state_next = S_CHECK;
               end
            end else if (r_to_cnt == TO_MAX) begin
               w_timeout    = 1'b1;
               w_state_next = S_IDLE;
               w_err_next   = 1'b1;
            end
         end
         S_CHECK: begin
            w_state_next = S_IDLE;
            w_err_next   = ~w_frame_ok;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_clk_sync  <= 2'b11;
         r_data_sync <= 2'b11;
         r_clk_prev  <= 1'b1;
         r_sreg      <= 10'd0;
         r_bitcnt    <= 4'd0;
         r_to_cnt    <= '0;
         r_kbd_data  <= 8'h00;
         r_kbd_ready <= 1'b0;
         r_overrun   <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_clk_sync  <= {r_clk_sync[0], ps2_clk};
         r_data_sync <= {r_data_sync[0], ps2_data};
         r_clk_prev  <= r_clk_sync[1];
         r_frame_err <= w_err_next;

         if (r_state == S_IDLE) begin
            r_bitcnt <= 4'd0;
         end else if (r_state == S_SHIFT && w_fall) begin
            r_sreg   <= {w_sample, r_sreg[9:1]};
            r_bitcnt <= r_bitcnt + 4'd1;
         end

         if (r_state == S_SHIFT && !w_fall && !w_timeout) begin
            r_to_cnt <= r_to_cnt + 1'b1;
         end else begin
            r_to_cnt <= '0;
         end

         // A read in the CHECK cycle frees the holding register for the incoming byte.
         if (w_load) begin
            r_kbd_data  <= r_sreg[7:0];
            r_kbd_ready <= 1'b1;
            r_overrun   <= 1'b0;
         end else if (w_accept) begin
            r_overrun   <= 1'b1;
         end else if (rd && r_kbd_ready) begin
            r_kbd_ready <= 1'b0;
            r_overrun   <= 1'b0;
         end
      end
   end

   assign kbd_data  = r_kbd_data;
   assign kbd_ready = r_kbd_ready;
   assign overrun   = r_overrun;
   assign frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: frames, overrun, parity/stop errors, timeout, CHECK-cycle read, reset.
module tb_ps2_kbd_rx;

   localparam int TO = 2000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       rd = 1'b0;
   logic [7:0] kbd_data;
   logic       kbd_ready;
   logic       overrun;
   logic       frame_err;

   int tests = 0;
   int fails = 0;
   int err_cnt = 0;

   ps2_kbd_rx #(.TIMEOUT_CYCLES(TO)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .rd        (rd),
      .kbd_data  (kbd_data),
      .kbd_ready (kbd_ready),
      .overrun   (overrun),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   // Counts every clk cycle in which frame_err is high.
   always @(posedge clk) if (frame_err === 1'b1) err_cnt++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
      $display("[TB] %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Drives the first nbits of a frame; leaves ps2_clk low on the last one and returns at that negedge.
   task automatic frame_begin(input logic [7:0] d, input logic pflip, input logic stopb, input int nbits);
      logic [10:0] bits;
      bits = {stopb, (~^d) ^ pflip, d, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_data = bits[i];
         repeat (3) @(negedge clk);
         ps2_clk = 1'b0;
         if (i != nbits - 1) begin
            repeat (8) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (4) @(negedge clk);
         end
      end
   endtask

   task automatic release_clk();
      repeat (6) @(negedge clk);
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] d, input logic pflip, input logic stopb);
      frame_begin(d, pflip, stopb, 11);
      release_clk();
   endtask

   task automatic do_rd();
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
   endtask

   initial begin
      int e0;
      int n;

      // Reset values
      repeat (4) @(negedge clk);
      check("rst_data", kbd_data, 8'h00);
      check("rst_ready", kbd_ready, 1'b0);
      check("rst_overrun", overrun, 1'b0);
      check("rst_frame_err", frame_err, 1'b0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // 0x1C with latency check from the stop-bit fall
      e0 = err_cnt;
      frame_begin(8'h1C, 1'b0, 1'b1, 11);
      repeat (3) @(negedge clk);
      check("lat3_ready", kbd_ready, 1'b0);
      @(negedge clk);
      check("lat4_ready", kbd_ready, 1'b1);
      check("1c_data", kbd_data, 8'h1C);
      release_clk();
      check("1c_no_err", err_cnt - e0, 0);
      do_rd();
      check("1c_rd_ready", kbd_ready, 1'b0);
      check("1c_rd_data", kbd_data, 8'h1C);

      // Overrun: F0 then 1C unread
      send(8'hF0, 1'b0, 1'b1);
      send(8'h1C, 1'b0, 1'b1);
      check("ovr_data", kbd_data, 8'hF0);
      check("ovr_ready", kbd_ready, 1'b1);
      check("ovr_flag", overrun, 1'b1);
      do_rd();
      check("ovr_rd_ready", kbd_ready, 1'b0);
      check("ovr_rd_flag", overrun, 1'b0);

      // Parity bit flipped
      e0 = err_cnt;
      send(8'h1C, 1'b1, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
      check("par_err", err_cnt - e0, 1);
      check("par_ready", kbd_ready, 1'b0);
      check("par_data", kbd_data, 8'hF0);
`else
      check("par_no_err", err_cnt - e0, 0);
      check("par_ready", kbd_ready, 1'b1);
      check("par_data", kbd_data, 8'h1C);
`endif
      do_rd();

      // Bad stop bit, then a good frame
      e0 = err_cnt;
      send(8'h5A, 1'b0, 1'b0);
      check("stop_err", err_cnt - e0, 1);
      check("stop_ready", kbd_ready, 1'b0);
      send(8'h5A, 1'b0, 1'b1);
      check("5a_data", kbd_data, 8'h5A);
      check("5a_ready", kbd_ready, 1'b1);
      check("5a_err_total", err_cnt - e0, 1);
      do_rd();

      // Timeout after start + 4 data bits
      e0 = err_cnt;
      frame_begin(8'hAA, 1'b0, 1'b1, 5);
      release_clk();
      n = 0;
      while (err_cnt == e0 && n < TO + 100) begin
         @(negedge clk);
         n++;
      end
      repeat (4) @(negedge clk);
      check("to_err", err_cnt - e0, 1);
      check("to_window", (n >= TO - 14 && n <= TO - 10) ? 1 : 0, 1);
      check("to_ready", kbd_ready, 1'b0);
      send(8'h29, 1'b0, 1'b1);
      check("29_data", kbd_data, 8'h29);
      check("29_ready", kbd_ready, 1'b1);
      check("29_err_total", err_cnt - e0, 1);
      do_rd();

      // Read in the CHECK cycle while F0 is unread
      send(8'hF0, 1'b0, 1'b1);
      check("f0_ready", kbd_ready, 1'b1);
      frame_begin(8'h32, 1'b0, 1'b1, 11);
      repeat (3) @(negedge clk);
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
      check("chkrd_data", kbd_data, 8'h32);
      check("chkrd_ready", kbd_ready, 1'b1);
      check("chkrd_overrun", overrun, 1'b0);
      release_clk();
      do_rd();
      check("chkrd_cleared", kbd_ready, 1'b0);

      // Reset mid-frame
      send(8'hF0, 1'b0, 1'b1);
      send(8'h1C, 1'b0, 1'b1);
      check("pre_rst_overrun", overrun, 1'b1);
      frame_begin(8'h33, 1'b0, 1'b1, 6);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      release_clk();
      check("mid_rst_data", kbd_data, 8'h00);
      check("mid_rst_ready", kbd_ready, 1'b0);
      check("mid_rst_overrun", overrun, 1'b0);
      check("mid_rst_err", frame_err, 1'b0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      e0 = err_cnt;
      send(8'h1C, 1'b0, 1'b1);
      check("post_rst_data", kbd_data, 8'h1C);
      check("post_rst_ready", kbd_ready, 1'b1);
      check("post_rst_overrun", overrun, 1'b0);
      check("post_rst_no_err", err_cnt - e0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ps2_kbd_rx.md
# ps2_kbd_rx

PS/2 keyboard receiver for the LC-3 keyboard device. It runs on the system clock and synchronizes the external `ps2_clk`/`ps2_data` pair. It deserializes device-to-host frames and holds the received scan code behind a KBSR/KBDR-style ready/read handshake. It sits between the PS/2 pins (or the keyboard stimulus model) and the memory-mapped I/O decode.

## Interface
- `TIMEOUT_CYCLES`, default 2000: idle clk cycles after the last `ps2_clk` falling edge before an in-progress frame is aborted.

- `clk`  input  1  system clock; all state updates on its rising edge.
- `rst_n`  input  1  synchronous, active-low reset.
- `ps2_clk`  input  1  raw PS/2 clock from the device; asynchronous to `clk`.
- `ps2_data`  input  1  raw PS/2 data; asynchronous to `clk`.
- `rd`  input  1  one-cycle KBDR read strobe from I/O decode.
- `kbd_data`  output  8  last accepted scan code (KBDR[7:0]).
- `kbd_ready`  output  1  byte available (KBSR[15]).
- `overrun`  output  1  sticky: a valid frame was dropped while `kbd_ready`=1.
- `frame_err`  output  1  one-cycle pulse: frame rejected or aborted.

## Operation
- Synchronization:
  - `ps2_clk` and `ps2_data` each pass through 2 flops.
  - A falling edge is registered prev=1, cur=0 on the synchronized clock.
  - `ps2_data` is sampled from its synchronizer in the same cycle the edge is detected.
- Frame format: 11 bits, LSB first.
  - start (0)
  - d[0]..d[7]
  - odd parity (d ^ p has odd weight)
  - stop (1)
- States:
  - IDLE:
    - On an edge with sampled data 0 → SHIFT, `bitcnt`=0.
    - On an edge with data 1, pulse `frame_err` and stay in IDLE.
  - SHIFT:
    - Each edge shifts the sample into `sreg[9:0]` (right shift, MSB in) and increments `bitcnt`.
    - After the 10th sample (8 data + parity + stop) → CHECK.
  - CHECK: one cycle.
    - Validate stop=1 and parity; then → IDLE.
    - Valid frame:
      - If `kbd_ready`=0, or `rd`=1 in this cycle: load `kbd_data`, set `kbd_ready`.
      - Otherwise set `overrun`; `kbd_data` is unchanged and the new byte is dropped.
    - Invalid frame: pulse `frame_err`; no register update.
- Timeout:
  - In SHIFT, a counter clears on every edge and increments otherwise.
  - Reaching `TIMEOUT_CYCLES`-1 → IDLE, pulse `frame_err`, discard partial data.
  - The counter width is $clog2(TIMEOUT_CYCLES).
- Read handshake:
  - `rd` clears `kbd_ready` and `overrun` next cycle.
  - `kbd_data` holds its value after the read.
  - `rd` with `kbd_ready`=0 has no effect.
- Simultaneous `rd` and a valid CHECK: the new byte loads, `kbd_ready` stays 1, and `overrun` clears.

## Timing
- Reset values:
  - `kbd_data`=8'h00, `kbd_ready`=0, `overrun`=0, `frame_err`=0.
  - State IDLE, `bitcnt`=0, timeout counter=0.
  - Synchronizer flops=1.
- Reset mid-frame: the partial frame is lost and the block returns to IDLE the next cycle.
- Latency from raw `ps2_clk` fall (stop bit) to `kbd_ready`=1:
  - 2 cycles synchronizer
  - 1 cycle edge detect/sample
  - 1 cycle CHECK
  - 4 `clk` cycles total, ±1 for input phase.
- `frame_err` is high for exactly one cycle per rejected frame.
- Input constraint: `ps2_clk` high and low phases each ≥3 `clk` periods; otherwise edges may be missed.
- All outputs are registered.

## Configuration
- `PS2_PARITY_CHECK_EN`:
  - Defined: a parity mismatch in CHECK rejects the frame with a `frame_err` pulse.
  - Undefined: the parity bit is shifted in but ignored, and only the stop bit is validated.
- Start-bit and timeout checking are always present.

## Test plan
- Reset, then send 0x1C (parity 0, stop 1) → after the stop edge + 4 cycles: `kbd_ready`=1, `kbd_data`=8'h1C, `frame_err` never pulses. Then `rd`=1 → `kbd_ready`=0 next cycle, `kbd_data` still 8'h1C.
- Send 0xF0 then 0x1C with no `rd` → `kbd_data`=8'hF0, `overrun`=1. Then `rd` → `kbd_ready`=0, `overrun`=0.
- Send 0x1C with parity bit 1:
  - With the macro defined: one `frame_err` pulse, `kbd_ready` stays 0.
  - Without the macro: `kbd_data`=8'h1C, `kbd_ready`=1.
- Send 0x5A with stop bit 0 → `frame_err` pulse, `kbd_ready`=0, state returns to IDLE. A following good 0x5A is accepted.
- Stop `ps2_clk` after 4 data bits for `TIMEOUT_CYCLES` cycles → `frame_err` pulse and IDLE. A following full 0x29 frame yields `kbd_data`=8'h29.
- Assert `rd` in the exact CHECK cycle of 0x32 while holding 0xF0 unread → `kbd_data`=8'h32, `kbd_ready`=1, `overrun`=0. Also assert `rst_n`=0 mid-frame → outputs at reset values; the next frame is received normally.
